// File: rtl/serial_sub_pkg.sv
// Shared definitions for the serial subtractor.
//   state_e      : FSM state encoding (idle / run / done)
//   DefaultWidth / DefaultBitsPerCycle : default parameter values
//   cnt_width()  : width of the slice counter for N slices, never below 1 bit
package serial_sub_pkg;

  localparam int unsigned DefaultWidth        = 8;
  localparam int unsigned DefaultBitsPerCycle = 1;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/full_subtractor1b.sv
// One-bit full subtractor: diff = a - b - bin, bout = borrow out.
//   a, b  : operand bits
//   bin   : borrow in
//   diff  : difference bit
//   bout  : borrow out (1 when a < b + bin)
module full_subtractor1b (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic diff,
  output logic bout
);

  assign diff = a ^ b ^ bin;
  assign bout = (~a & b) | (~a & bin) | (b & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Multi-cycle unsigned subtractor: diff = x - y - bin, BITS_PER_CYCLE bits per clock, LSB first.
// Build option: define SERIAL_SUB_SAT_EN for a saturating subtract (diff forced to 0 when the
// final borrow is set; borrow still reports 1). Without it diff is the wrapped result.
//   clk, rst_n : clock (rising edge), asynchronous active-low reset
//   start      : request; accepted in idle or done state
//   x, y, bin  : minuend, subtrahend, borrow-in, captured on the accepting edge
//   busy       : high while the slices are being processed
//   done       : one-cycle pulse, diff/borrow valid
//   diff       : result, held until the next result
//   borrow     : borrow-out of the MSB
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int unsigned WIDTH          = DefaultWidth,
  parameter int unsigned BITS_PER_CYCLE = DefaultBitsPerCycle
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
);

  localparam int unsigned N    = (BITS_PER_CYCLE == 0) ? 1 : WIDTH / BITS_PER_CYCLE;
  localparam int unsigned CntW = cnt_width(N);
  localparam logic [CntW-1:0] CntLast = CntW'(N - 1);

  if (WIDTH < 2 || BITS_PER_CYCLE == 0 || (WIDTH % BITS_PER_CYCLE) != 0) begin : g_bad_cfg
    $fatal(1, "serial_subtractor: WIDTH must be >= 2 and a multiple of BITS_PER_CYCLE");
  end

  state_e state_q, state_d;

  logic [WIDTH-1:0] x_q, y_q, res_q, diff_q;
  logic             bq, borrow_q;
  logic [CntW-1:0]  cnt_q;

  logic [BITS_PER_CYCLE:0]   chain;
  logic [BITS_PER_CYCLE-1:0] slice_d;
  logic [WIDTH-1:0]          res_shift;
  logic                      last, accept, running;

  // Borrow chain across the low slice of the operand registers.
  assign chain[0] = bq;
  for (genvar gi = 0; gi < BITS_PER_CYCLE; gi++) begin : g_slice
    full_subtractor1b u_fs (
      .a    (x_q[gi]),
      .b    (y_q[gi]),
      .bin  (chain[gi]),
      .diff (slice_d[gi]),
      .bout (chain[gi+1])
    );
  end

  // New slice enters at the MSB end; after N shifts the LSB slice sits at bit 0.
  assign res_shift = (res_q >> BITS_PER_CYCLE) | (WIDTH'(slice_d) << (WIDTH - BITS_PER_CYCLE));

  assign last    = (cnt_q == CntLast);
  assign running = (state_q == StRun);
  assign accept  = start && (state_q == StIdle || state_q == StDone);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StRun;
      StRun:   if (last) state_d = StDone;
      StDone:  state_d = start ? StRun : StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Output logic
  always_comb begin
    busy   = 1'b0;
    done   = 1'b0;
    busy   = (state_q == StRun);
    done   = (state_q == StDone);
    diff   = diff_q;
    borrow = borrow_q;
  end

  // Datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q      <= '0;
      y_q      <= '0;
      res_q    <= '0;
      bq       <= 1'b0;
      cnt_q    <= '0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
    end else if (accept) begin
      x_q   <= x;
      y_q   <= y;
      bq    <= bin;
      res_q <= '0;
      cnt_q <= '0;
    end else if (running) begin
      x_q   <= x_q >> BITS_PER_CYCLE;
      y_q   <= y_q >> BITS_PER_CYCLE;
      res_q <= res_shift;
      bq    <= chain[BITS_PER_CYCLE];
      cnt_q <= cnt_q + CntW'(1);
      if (last) begin
`ifdef SERIAL_SUB_SAT_EN
        diff_q <= chain[BITS_PER_CYCLE] ? '0 : res_shift;
`else
        diff_q <= res_shift;
`endif
        borrow_q <= chain[BITS_PER_CYCLE];
      end
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and random checks of serial_subtractor with WIDTH=8 for BITS_PER_CYCLE 1 and 4.
module tb_serial_subtractor;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic       start1 = 1'b0, bin1 = 1'b0, busy1, done1, borrow1;
  logic [7:0] x1 = '0, y1 = '0, diff1;
  logic       start4 = 1'b0, bin4 = 1'b0, busy4, done4, borrow4;
  logic [7:0] x4 = '0, y4 = '0, diff4;

  int checks = 0;
  int failures = 0;
  int dcnt [2];
  int accepts [2];

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(8), .BITS_PER_CYCLE(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .x(x1), .y(y1), .bin(bin1),
    .busy(busy1), .done(done1), .diff(diff1), .borrow(borrow1)
  );

  serial_subtractor #(.WIDTH(8), .BITS_PER_CYCLE(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .x(x4), .y(y4), .bin(bin4),
    .busy(busy4), .done(done4), .diff(diff4), .borrow(borrow4)
  );

  initial begin
    dcnt[0] = 0;
    dcnt[1] = 0;
    accepts[0] = 0;
    accepts[1] = 0;
  end

  always @(posedge clk) begin
    if (done1) dcnt[0] <= dcnt[0] + 1;
    if (done4) dcnt[1] <= dcnt[1] + 1;
  end

  typedef struct {
    int         sel;   // 0: B=1 instance, 1: B=4 instance
    logic [7:0] x;
    logic [7:0] y;
    logic       bi;
    logic [7:0] d;     // wrapped difference
    logic       bo;
    int         lat;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] sat(input logic [7:0] d, input logic bo);
`ifdef SERIAL_SUB_SAT_EN
    return bo ? 8'h00 : d;
`else
    return d;
`endif
  endfunction

  task automatic drive(input int sel, input logic s, input logic [7:0] a, input logic [7:0] b,
                       input logic bi);
    if (sel == 0) begin
      start1 = s; x1 = a; y1 = b; bin1 = bi;
    end else begin
      start4 = s; x4 = a; y4 = b; bin4 = bi;
    end
  endtask

  task automatic sample(input int sel, output logic bsy, output logic dn, output logic [7:0] d,
                        output logic bo);
    if (sel == 0) begin
      bsy = busy1; dn = done1; d = diff1; bo = borrow1;
    end else begin
      bsy = busy4; dn = done4; d = diff4; bo = borrow4;
    end
  endtask

  // Counts edges after the current point until done is seen; returns on the done-cycle negedge.
  task automatic wait_done(input int sel, output logic [7:0] d, output logic bo, output int lat);
    logic bsy, dn;
    bit found = 0;
    lat = 0;
    d = '0;
    bo = 1'b0;
    for (int k = 1; k <= 20 && !found; k++) begin
      @(posedge clk);
      @(negedge clk);
      sample(sel, bsy, dn, d, bo);
      if (dn) begin
        found = 1;
        lat = k;
        chk("busy_low_at_done", int'(bsy), 0);
      end else begin
        chk("busy_during_run", int'(bsy), 1);
      end
    end
    if (!found) chk("done_timeout", 0, 1);
  endtask

  task automatic run_op(input int sel, input logic [7:0] a, input logic [7:0] b, input logic bi,
                        output logic [7:0] d, output logic bo, output int lat);
    @(negedge clk);
    drive(sel, 1'b1, a, b, bi);
    @(posedge clk);
    #1 drive(sel, 1'b0, 8'h00, 8'h00, 1'b0);
    accepts[sel]++;
    wait_done(sel, d, bo, lat);
  endtask

  vec_t vecs [12];

  initial begin
    logic [7:0] d;
    logic       bo, bsy, dn;
    int         lat, dc;
    logic [8:0] full;

    vecs[0]  = '{0, 8'h5A, 8'h3C, 1'b0, 8'h1E, 1'b0, 8};
    vecs[1]  = '{0, 8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 8};
    vecs[2]  = '{0, 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 8};
    vecs[3]  = '{0, 8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 8};
    vecs[4]  = '{0, 8'hFF, 8'h00, 1'b0, 8'hFF, 1'b0, 8};
    vecs[5]  = '{0, 8'h33, 8'h11, 1'b1, 8'h21, 1'b0, 8};
    vecs[6]  = '{1, 8'h10, 8'h01, 1'b0, 8'h0F, 1'b0, 2};
    vecs[7]  = '{1, 8'hA5, 8'h5A, 1'b0, 8'h4B, 1'b0, 2};
    vecs[8]  = '{1, 8'h00, 8'hFF, 1'b1, 8'h00, 1'b1, 2};
    vecs[9]  = '{1, 8'h7F, 8'h80, 1'b0, 8'hFF, 1'b1, 2};
    vecs[10] = '{1, 8'h03, 8'h05, 1'b0, 8'hFE, 1'b1, 2};
    vecs[11] = '{1, 8'h5A, 8'h3C, 1'b0, 8'h1E, 1'b0, 2};

    // Reset state
    repeat (2) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      sample(s, bsy, dn, d, bo);
      chk("reset_busy", int'(bsy), 0);
      chk("reset_done", int'(dn), 0);
      chk("reset_diff", int'(d), 0);
      chk("reset_borrow", int'(bo), 0);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Directed table
    foreach (vecs[i]) begin
      run_op(vecs[i].sel, vecs[i].x, vecs[i].y, vecs[i].bi, d, bo, lat);
      chk($sformatf("vec%0d_diff", i), int'(d), int'(sat(vecs[i].d, vecs[i].bo)));
      chk($sformatf("vec%0d_borrow", i), int'(bo), int'(vecs[i].bo));
      chk($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
    end

    // Start during RUN is ignored; done pulses once and result holds afterwards
    @(negedge clk);
    dc = dcnt[0];
    drive(0, 1'b1, 8'h80, 8'h7F, 1'b1);
    @(posedge clk);
    #1 drive(0, 1'b0, 8'h00, 8'h00, 1'b0);
    accepts[0]++;
    repeat (3) @(posedge clk);
    @(negedge clk);
    drive(0, 1'b1, 8'h11, 8'h22, 1'b0);
    @(posedge clk);
    #1 drive(0, 1'b0, 8'h00, 8'h00, 1'b0);
    wait_done(0, d, bo, lat);
    chk("ignored_start_diff", int'(d), 8'h00);
    chk("ignored_start_borrow", int'(bo), 0);
    chk("ignored_start_latency", lat + 4, 8);
    @(negedge clk);
    chk("done_one_cycle", int'(done1), 0);
    repeat (12) @(negedge clk);
    chk("ignored_start_one_done", dcnt[0] - dc, 1);
    chk("hold_diff", int'(diff1), 8'h00);
    chk("hold_busy", int'(busy1), 0);

    // Back-to-back accept from the DONE cycle
    run_op(1, 8'h10, 8'h01, 1'b0, d, bo, lat);
    chk("b2b_first_diff", int'(d), 8'h0F);
    chk("b2b_first_borrow", int'(bo), 0);
    drive(1, 1'b1, 8'h03, 8'h05, 1'b0);
    @(posedge clk);
    #1 drive(1, 1'b0, 8'h00, 8'h00, 1'b0);
    accepts[1]++;
    wait_done(1, d, bo, lat);
    chk("b2b_second_diff", int'(d), int'(sat(8'hFE, 1'b1)));
    chk("b2b_second_borrow", int'(bo), 1);
    chk("b2b_second_latency", lat, 2);

    // Reset mid-run aborts without a done pulse
    @(negedge clk);
    drive(0, 1'b1, 8'hFF, 8'h0F, 1'b0);
    @(posedge clk);
    #1 drive(0, 1'b0, 8'h00, 8'h00, 1'b0);
    repeat (4) @(posedge clk);
    dc = dcnt[0];
    #1 rst_n = 1'b0;
    #1;
    sample(0, bsy, dn, d, bo);
    chk("abort_busy", int'(bsy), 0);
    chk("abort_done", int'(dn), 0);
    chk("abort_diff", int'(d), 0);
    chk("abort_borrow", int'(bo), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    chk("abort_no_done", dcnt[0] - dc, 0);
    run_op(0, 8'hFF, 8'h0F, 1'b0, d, bo, lat);
    chk("after_abort_diff", int'(d), 8'hF0);
    chk("after_abort_borrow", int'(bo), 0);
    chk("after_abort_latency", lat, 8);

    // Random sweep on both instances
    for (int s = 0; s < 2; s++) begin
      for (int n = 0; n < 1000; n++) begin
        logic [7:0] a, b;
        logic       bi;
        a = 8'($urandom_range(0, 255));
        b = 8'($urandom_range(0, 255));
        bi = 1'($urandom_range(0, 1));
        full = {1'b0, a} - {1'b0, b} - {8'h00, bi};
        run_op(s, a, b, bi, d, bo, lat);
        chk($sformatf("rand_b%0d_diff %0h-%0h-%0h", s, a, b, bi), int'(d),
            int'(sat(full[7:0], full[8])));
        chk($sformatf("rand_b%0d_borrow %0h-%0h-%0h", s, a, b, bi), int'(bo), int'(full[8]));
      end
    end

    repeat (3) @(negedge clk);
    chk("done_count_b1", dcnt[0], accepts[0]);
    chk("done_count_b4", dcnt[1], accepts[1]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Absolute time guard
  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
